div_iter: RTL and testbench

//  Iterative 32-bit restoring divider, signed and unsigned, one quotient bit per cycle.

---
 rtl/div_iter_pkg.sv | 26 ++
 rtl/div_iter.sv | 192 +++++++++++++++++++
 tb/tb_div_iter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// ----------------------------------------------------------------------------
// div_iter_pkg
//   Shared definitions for the iterative divider beside the execute stage:
//   FSM state encoding, ready/start level names and word-width constants.
//   The state codes keep the 2-bit values the rest of the pipeline expects.
// ----------------------------------------------------------------------------
package div_iter_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [DIV_DATA_W-1:0]   ZERO_WORD       = '0;
    localparam logic [2*DIV_DATA_W-1:0] ZERO_DOUBLE_REG = '0;

endpackage

// File: rtl/div_iter.sv
// ----------------------------------------------------------------------------
// div_iter
//   Iterative restoring divider, one quotient bit per clock, serving DIV
//   (signed) and DIVU (unsigned). EX drives operands and holds start_i until
//   ready_o; the result goes back as {remainder, quotient} for HI/LO.
//
// Parameters
//   DATA_W        operand width (counter is clog2(DATA_W)+1 bits)
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset, overrides everything
//   signed_div_i  1 = two's-complement operands, 0 = unsigned
//   opdata1_i     dividend, sampled only on the start edge
//   opdata2_i     divisor, sampled only on the start edge
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       cancels an in-flight divide (ignored once result is ready)
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//
// Build option
//   DIV_EARLY_OUT_EN  when defined, a divide with |op1| < |op2| finishes on
//                     the start edge with quotient 0, remainder op1.
// ----------------------------------------------------------------------------
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int DVD_W = 2*DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_e         state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [DVD_W-1:0]   dividend, dividend_next;
    logic [DATA_W-1:0]  divisor, divisor_next;
    logic               op1_sign, op1_sign_next;
    logic               op2_sign, op2_sign_next;
    logic               signed_mode, signed_mode_next;
    logic [2*DATA_W-1:0] result_next;
    logic               ready_next;

    logic [DATA_W-1:0]  neg_a_src, neg_b_src, neg_a, neg_b;
    logic [DATA_W-1:0]  mag1, mag2;
    logic [DATA_W:0]    window, diff;
    logic [DATA_W-1:0]  quo_raw, rem_raw, quo_fix, rem_fix;

    // One pair of negators serves both ends of a divide: while idle they turn
    // the incoming operands into magnitudes, and while iterating they feed the
    // sign fix-up of the finished quotient and remainder.
    always_comb begin
        neg_a_src = (state == DivOn) ? quo_raw : opdata1_i;
        neg_b_src = (state == DivOn) ? rem_raw : opdata2_i;
        neg_a     = -neg_a_src;
        neg_b     = -neg_b_src;
        mag1      = (signed_div_i && opdata1_i[DATA_W-1]) ? neg_a : opdata1_i;
        mag2      = (signed_div_i && opdata2_i[DATA_W-1]) ? neg_b : opdata2_i;
    end

    // The partial remainder lives in dividend[2W:W+1]; the trial window is the
    // remainder shifted left with the next dividend bit appended. A borrow out
    // of the (W+1)-bit subtraction means the divisor did not fit.
    always_comb begin
        quo_raw = dividend[DATA_W-1:0];
        rem_raw = dividend[DVD_W-1:DATA_W+1];
        window  = dividend[DVD_W-1:DATA_W];
        diff    = window - {1'b0, divisor};
        quo_fix = (signed_mode && (op1_sign ^ op2_sign)) ? neg_a : quo_raw;
        rem_fix = (signed_mode && op1_sign) ? neg_b : rem_raw;
    end

    // Next-state and datapath decisions for every register.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        dividend_next    = dividend;
        divisor_next     = divisor;
        op1_sign_next    = op1_sign;
        op2_sign_next    = op2_sign;
        signed_mode_next = signed_mode;
        result_next      = result_o;
        ready_next       = ready_o;

        case (state)
            DivFree: begin
                ready_next  = DIV_RESULT_NOT_READY;
                result_next = ZERO_DOUBLE_REG;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = DivByZero;
`ifdef DIV_EARLY_OUT_EN
                    end else if (mag1 < mag2) begin
                        state_next  = DivEnd;
                        result_next = {opdata1_i, {DATA_W{1'b0}}};
                        ready_next  = DIV_RESULT_READY;
`endif
                    end else begin
                        state_next       = DivOn;
                        cnt_next         = '0;
                        dividend_next    = {{DATA_W{1'b0}}, mag1, 1'b0};
                        divisor_next     = mag2;
                        op1_sign_next    = opdata1_i[DATA_W-1];
                        op2_sign_next    = opdata2_i[DATA_W-1];
                        signed_mode_next = signed_div_i;
                    end
                end
            end

            DivByZero: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    ready_next  = DIV_RESULT_NOT_READY;
                    result_next = ZERO_DOUBLE_REG;
                end else begin
                    state_next  = DivEnd;
                    ready_next  = DIV_RESULT_READY;
                    result_next = ZERO_DOUBLE_REG;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    ready_next  = DIV_RESULT_NOT_READY;
                    result_next = ZERO_DOUBLE_REG;
                end else if (cnt != CNT_LAST) begin
                    if (diff[DATA_W]) begin
                        dividend_next = dividend << 1;
                    end else begin
                        dividend_next = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
                    end
                    cnt_next = cnt + 1'b1;
                end else begin
                    state_next  = DivEnd;
                    result_next = {rem_fix, quo_fix};
                    ready_next  = DIV_RESULT_READY;
                end
            end

            DivEnd: begin
                if (start_i == DIV_STOP) begin
                    state_next  = DivFree;
                    ready_next  = DIV_RESULT_NOT_READY;
                    result_next = ZERO_DOUBLE_REG;
                end
            end

            default: begin
                state_next  = DivFree;
                ready_next  = DIV_RESULT_NOT_READY;
                result_next = ZERO_DOUBLE_REG;
            end
        endcase
    end

    // State register; reset clears the whole divider regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DivFree;
            cnt         <= '0;
            dividend    <= '0;
            divisor     <= ZERO_WORD;
            op1_sign    <= 1'b0;
            op2_sign    <= 1'b0;
            signed_mode <= 1'b0;
            result_o    <= ZERO_DOUBLE_REG;
            ready_o     <= DIV_RESULT_NOT_READY;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            dividend    <= dividend_next;
            divisor     <= divisor_next;
            op1_sign    <= op1_sign_next;
            op2_sign    <= op2_sign_next;
            signed_mode <= signed_mode_next;
            result_o    <= result_next;
            ready_o     <= ready_next;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// ----------------------------------------------------------------------------
// tb_div_iter
//   Directed and random checks of div_iter: expected {remainder, quotient}
//   values go into a queue when a divide is issued and are popped when
//   ready_o rises. Latency, hold, release, annul and reset are checked too.
//   Follows DIV_EARLY_OUT_EN for the expected latency of small dividends.
// ----------------------------------------------------------------------------
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_iter #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference divide built from the language's own / and %, on magnitudes.
    function automatic logic [63:0] modelDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] ma, mb, q, r;
        logic na, nb;
        if (b == 32'd0) return 64'd0;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r, q};
    endfunction

    function automatic int expLatency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] ma, mb;
        ma = (sgn & a[31]) ? -a : a;
        mb = (sgn & b[31]) ? -b : b;
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return (ma == mb) ? 34 : 34;
    endfunction

    // Issue a divide: push the expectation and drive the start edge (E0).
    // Operands are scrambled afterwards to show the latched copy is used.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic [63:0] expv);
        exp_q.push_back(expv);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
    endtask

    // Wait (bounded) for ready_o, then check latency and the popped result.
    task automatic checkResult(input string tag, input int lat);
        int edges;
        logic [63:0] expv;
        edges = 1;
        while (!ready_o && edges < 40) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_latency"}, 64'(edges), 64'(lat));
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            expv = exp_q.pop_front();
            checkOutput({tag, "_result"}, result_o, expv);
        end
    endtask

    task automatic releaseStart(input string tag);
        start_i = 1'b0;
        tick();
        checkOutput({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
        checkOutput({tag, "_rel_result"}, result_o, 64'd0);
    endtask

    task automatic fullDivide(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        applyStimulus(a, b, sgn, modelDiv(a, b, sgn));
        checkResult(tag, expLatency(a, b, sgn));
        releaseStart(tag);
    endtask

    initial begin
        int rises;
        logic [63:0] held;
        logic [31:0] ra, rb;
        logic rs;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) tick();
        checkOutput("reset_ready", 64'(ready_o), 64'd0);
        checkOutput("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick();
        $display("[TB] reset released");

        // Directed divides with hand-computed results.
        applyStimulus(32'd7, 32'd2, 1'b1, 64'h00000001_00000003);
        checkResult("t1_7_2", 34);
        releaseStart("t1");
        applyStimulus(-32'sd7, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        checkResult("t2_m7_2", 34);
        releaseStart("t2");
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
        checkResult("t2_overflow", 34);
        releaseStart("t2o");
        applyStimulus(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF);
        checkResult("t3_unsigned", 34);
        releaseStart("t3u");
        applyStimulus(32'hFFFFFFFF, 32'h10, 1'b1, 64'hFFFFFFFF_00000000);
        checkResult("t3_signed", expLatency(32'hFFFFFFFF, 32'h10, 1'b1));
        releaseStart("t3s");
        applyStimulus(32'hFFFFFFFF, 32'h80000001, 1'b0, 64'h7FFFFFFE_00000001);
        checkResult("big_divisor", 34);
        releaseStart("big");

        // Divide by zero, held result, annul ignored once done.
        applyStimulus(32'd5, 32'd0, 1'b0, 64'd0);
        checkResult("t4_div0", 2);
        held = result_o;
        for (int i = 0; i < 3; i++) begin
            annul_i = (i == 1);
            tick();
            checkOutput("t4_hold_ready", 64'(ready_o), 64'd1);
            checkOutput("t4_hold_result", result_o, held);
        end
        annul_i = 1'b0;
        releaseStart("t4");

        // Annul mid-divide: no result may ever appear.
        opdata1_i = 32'd100; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        checkOutput("t5_annul_result", result_o, 64'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) rises++;
        end
        checkOutput("t5_no_ready", 64'(rises), 64'd0);
        applyStimulus(32'd100, 32'd3, 1'b0, 64'h00000001_00000021);
        checkResult("t5_restart", 34);
        releaseStart("t5");

        // Annul while waiting on a divide by zero.
        opdata1_i = 32'd9; opdata2_i = 32'd0; start_i = 1'b1;
        tick();
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ready_o) rises++;
        end
        checkOutput("div0_annul_no_ready", 64'(rises), 64'd0);

        // Reset mid-divide and while a result is being held.
        opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        repeat (20) tick();
        rst = 1'b1; start_i = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_ready", 64'(ready_o), 64'd0);
        checkOutput("t6_rst_result", result_o, 64'd0);
        applyStimulus(32'd7, 32'd2, 1'b1, 64'h00000001_00000003);
        checkResult("t6_after_rst", 34);
        rst = 1'b1; start_i = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_end_ready", 64'(ready_o), 64'd0);
        checkOutput("t6_rst_end_result", result_o, 64'd0);
        exp_q.delete();

        // Small dividend: early-out latency when enabled, full otherwise.
        applyStimulus(32'd3, 32'd100, 1'b0, 64'h00000003_00000000);
        checkResult("t6_small", expLatency(32'd3, 32'd100, 1'b0));
        releaseStart("t6s");
        applyStimulus(-32'sd3, 32'd100, 1'b1, 64'hFFFFFFFD_00000000);
        checkResult("small_neg", expLatency(-32'sd3, 32'd100, 1'b1));
        releaseStart("small_neg");

        // Random operands, both modes.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            rs = 1'(i % 3 != 0);
            fullDivide($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
